xadc_drp_sampler: RTL

Upstream front-end for the XADC display path. It converts XADC end-of-conversion events into single DRP read transactions on the channel selected by sw. It then averages 2^AVG_LOG2 consecutive 12-bit results and presents each averaged code to the digit-conversion/display logic with a one-cycle valid strobe. It replaces the direct eoc-to-den wiring and adds address stability, a drdy timeout and channel-change flushing.

---
 rtl/xadc_pkg.sv | 40 ++++
 rtl/xadc_drp_sampler_if.sv | 32 +++
 rtl/xadc_avg_accum.sv | 85 ++++++++
 rtl/xadc_drp_sampler.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_pkg
//  Description : Shared constants, FSM state encoding and the channel-select
//                to DRP-address mapping for the XADC sampling front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package xadc_pkg;

    // Width of an XADC conversion result, held in do_out[15:4]
    localparam int XADC_CODE_W = 12;

    // DRP status-register addresses of the four auxiliary channels in use
    localparam logic [6:0] ADDR_VAUX6  = 7'h16;
    localparam logic [6:0] ADDR_VAUX7  = 7'h17;
    localparam logic [6:0] ADDR_VAUX14 = 7'h1E;
    localparam logic [6:0] ADDR_VAUX15 = 7'h1F;

    // Read-sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACC  = 2'd3
    } state_t;

    // Map the 2-bit channel select onto the DRP address of its channel
    function automatic logic [6:0] sw_to_addr(input logic [1:0] sel);
        logic [6:0] addr;
        case (sel)
            2'd0:    addr = ADDR_VAUX6;
            2'd1:    addr = ADDR_VAUX7;
            2'd2:    addr = ADDR_VAUX14;
            default: addr = ADDR_VAUX15;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xadc_drp_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_drp_sampler_if
//  Description : XADC event/DRP handshake plus the averaged-sample output
//                towards the display logic. The sampler is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xadc_drp_sampler_if;
    import xadc_pkg::*;

    logic                   eoc_in;
    logic                   drdy_in;
    logic [15:0]            do_in;
    logic                   den_out;
    logic [6:0]             daddr_out;
    logic [XADC_CODE_W-1:0] sample_out;
    logic                   sample_valid;
    logic [1:0]             channel_out;
    logic                   timeout_err;

    modport master (
        input  eoc_in, drdy_in, do_in,
        output den_out, daddr_out, sample_out, sample_valid, channel_out, timeout_err
    );

    modport slave (
        output eoc_in, drdy_in, do_in,
        input  den_out, daddr_out, sample_out, sample_valid, channel_out, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/xadc_avg_accum.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_avg_accum
//  Description : Sums 2^AVG_LOG2 consecutive codes of one channel and emits
//                the truncated mean with a one-cycle valid. A sample from a
//                different channel than the partial sum restarts the average.
//  Revision    : 1.0 - initial release
// ============================================================================
module xadc_avg_accum
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_add_en,
    input  wire logic [XADC_CODE_W-1:0] i_code,
    input  wire logic [1:0]             i_chan,
    output logic      [XADC_CODE_W-1:0] o_sample,
    output logic                        o_valid,
    output logic      [1:0]             o_channel
);

    localparam int c_ACC_W = XADC_CODE_W + AVG_LOG2;
    localparam int c_CNT_W = AVG_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(1) << AVG_LOG2;

    logic [c_ACC_W-1:0]     r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [1:0]             r_acc_chan;
    logic [XADC_CODE_W-1:0] r_sample;
    logic                   r_valid;
    logic [1:0]             r_channel;

    logic                   w_flush;
    logic [c_ACC_W-1:0]     w_base_acc;
    logic [c_CNT_W-1:0]     w_base_cnt;
    logic [c_ACC_W-1:0]     w_sum;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic                   w_full;

    // Next sum and count, discarding a partial sum that belongs to another channel
    always_comb begin
        w_flush    = (r_cnt != '0) && (i_chan != r_acc_chan);
        w_base_acc = w_flush ? '0 : r_acc;
        w_base_cnt = w_flush ? '0 : r_cnt;
        w_sum      = w_base_acc + c_ACC_W'(i_code);
        w_cnt_next = w_base_cnt + c_CNT_W'(1);
        w_full     = (w_cnt_next == c_FULL);
    end

    // Accumulate; on the final sample of a group publish the mean and restart
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_acc_chan <= 2'd0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_channel  <= 2'd0;
        end else begin
            r_valid <= 1'b0;
            if (i_add_en) begin
                r_acc_chan <= i_chan;
                if (w_full) begin
                    // Top XADC_CODE_W bits of the sum are the sum shifted right by AVG_LOG2
                    r_sample  <= w_sum[c_ACC_W-1 -: XADC_CODE_W];
                    r_valid   <= 1'b1;
                    r_channel <= i_chan;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign o_sample  = r_sample;
    assign o_valid   = r_valid;
    assign o_channel = r_channel;

endmodule
`default_nettype wire

// File: rtl/xadc_drp_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_drp_sampler
//  Description : Turns XADC end-of-conversion events into single DRP reads on
//                the selected channel, guards each read with a drdy timeout
//                and feeds the results into the averaging stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module xadc_drp_sampler
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 255
) (
    input  wire logic       CLK100MHZ,
    input  wire logic       reset,
    input  wire logic [1:0] sw,
    xadc_drp_sampler_if.master bus
);

    // Last WAIT cycle index before the read is abandoned
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_sw_q;
    logic                   r_den;
    logic [6:0]             r_daddr;
    logic [1:0]             r_rd_chan;
    logic [XADC_CODE_W-1:0] r_code;
    logic [7:0]             r_tmo_cnt;
    logic                   r_timeout_err;

    logic                   w_start;
    logic                   w_den_set;
    logic                   w_tmo_clr;
    logic                   w_tmo_inc;
    logic                   w_tmo_fire;
    logic                   w_take_code;
    logic                   w_acc_add;
    logic                   w_unused_do;

    // Low nibble of do_out carries no part of the 12-bit code
    assign w_unused_do = ^bus.do_in[3:0];

    // Register the channel select once before it steers the address
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_sw_q <= 2'd0;
        end else begin
            r_sw_q <= sw;
        end
    end

    // Sequencer state register
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next-state and per-state control strobes
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_den_set    = 1'b0;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        w_tmo_fire   = 1'b0;
        w_take_code  = 1'b0;
        w_acc_add    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.eoc_in) begin
                    w_start      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_den_set    = 1'b1;
                w_tmo_clr    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.drdy_in) begin
                    w_take_code  = 1'b1;
                    w_state_next = ST_ACC;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_tmo_fire   = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_tmo_inc    = 1'b1;
                end
            end
            ST_ACC: begin
                w_acc_add    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // DRP request registers: den pulse, address/channel held for the whole read,
    // drdy timeout counter, sticky timeout flag and the captured code
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_den         <= 1'b0;
            r_daddr       <= ADDR_VAUX6;
            r_rd_chan     <= 2'd0;
            r_code        <= '0;
            r_tmo_cnt     <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_den <= w_den_set;
            if (w_start) begin
                r_daddr   <= sw_to_addr(r_sw_q);
                r_rd_chan <= r_sw_q;
            end
            if (w_tmo_clr) begin
                r_tmo_cnt <= 8'd0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_take_code) begin
                r_code <= bus.do_in[15:4];
            end
            if (w_tmo_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    xadc_avg_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk       (CLK100MHZ),
        .rst       (reset),
        .i_add_en  (w_acc_add),
        .i_code    (r_code),
        .i_chan    (r_rd_chan),
        .o_sample  (bus.sample_out),
        .o_valid   (bus.sample_valid),
        .o_channel (bus.channel_out)
    );

    assign bus.den_out     = r_den;
    assign bus.daddr_out   = r_daddr;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire
